spi_ram_arbiter: RTL

//  Sits between the SPI slave and the single-port RAM. Decodes 10-bit SPI command words
//  {op[1:0], payload[7:0]} into RAM accesses. Shares the one RAM port, round-robin, with a

---
 rtl/spi_ram_arbiter_if.sv | 30 +++
 rtl/spi_ram_arbiter.sv | 84 ++++++++
 2 files changed

// File: rtl/spi_ram_arbiter_if.sv
// spi_ram_arbiter_if: SPI word, host requester and RAM port signals of the arbiter
interface spi_ram_arbiter_if #(parameter int ADDR_SIZE = 8);
  logic [9:0] rx_data;
  logic rx_valid;
  logic [7:0] tx_data;
  logic tx_valid;
  logic host_req;
  logic host_we;
  logic [ADDR_SIZE-1:0] host_addr;
  logic [7:0] host_wdata;
  logic host_gnt;
  logic [7:0] host_rdata;
  logic host_rvalid;
  logic ram_en;
  logic ram_we;
  logic [ADDR_SIZE-1:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
  logic cmd_err;
  modport slave (
    input rx_data, rx_valid, host_req, host_we, host_addr, host_wdata, ram_rdata,
    output tx_data, tx_valid, host_gnt, host_rdata, host_rvalid, ram_en, ram_we, ram_addr,
           ram_wdata, cmd_err
  );
  modport master (
    output rx_data, rx_valid, host_req, host_we, host_addr, host_wdata, ram_rdata,
    input tx_data, tx_valid, host_gnt, host_rdata, host_rvalid, ram_en, ram_we, ram_addr,
          ram_wdata, cmd_err
  );
endinterface

// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: decodes SPI command words into RAM accesses, sharing the RAM port
// round-robin with a host requester
module spi_ram_arbiter #(
  parameter int ADDR_SIZE = 8,
  parameter bit AUTO_INC = 1'b1
) (
  input logic clk,
  input logic rst_n,
  spi_ram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACC, RDCAP} state_t;
  state_t state, state_d;
  logic rx_q, pend, wa_set, ra_set, last_spi, win_spi, is_rd;
  logic cap, cfg, spi_req, bad, host_go, spi_go, pend_clr;
  logic [9:0] cmd;
  logic [ADDR_SIZE-1:0] wr_addr, rd_addr;
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_d;
  always_comb begin
    cap = bus.rx_valid && !rx_q;
    cfg = state == IDLE && pend && !cmd[8];
    spi_req = state == IDLE && pend && cmd[8] && (cmd[9] ? ra_set : wa_set);
    bad = state == IDLE && pend && cmd[8] && !(cmd[9] ? ra_set : wa_set);
    host_go = state == IDLE && bus.host_req && (!spi_req || last_spi);
    spi_go = spi_req && !host_go;
    pend_clr = cfg || bad || spi_go;
    state_d = state == IDLE ? ((spi_go || host_go) ? ACC : IDLE) :
              (state == ACC && is_rd) ? RDCAP : IDLE;
  end
  // The access is fully registered at grant time, so pend and the pointer move on here
  // and a command captured during ACC/RDCAP survives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_q <= 1'b0;
      pend <= 1'b0;
      cmd <= '0;
      wa_set <= 1'b0;
      ra_set <= 1'b0;
      wr_addr <= '0;
      rd_addr <= '0;
      last_spi <= 1'b0;
      win_spi <= 1'b0;
      is_rd <= 1'b0;
      bus.tx_data <= '0;
      bus.tx_valid <= 1'b0;
      bus.host_gnt <= 1'b0;
      bus.host_rdata <= '0;
      bus.host_rvalid <= 1'b0;
      bus.ram_en <= 1'b0;
      bus.ram_we <= 1'b0;
      bus.ram_addr <= '0;
      bus.ram_wdata <= '0;
      bus.cmd_err <= 1'b0;
    end else begin
      rx_q <= bus.rx_valid;
      if (cap) cmd <= bus.rx_data;
      pend <= cap || (pend && !pend_clr);
      bus.cmd_err <= (cap && pend && !pend_clr) || bad;
      if (cfg && !cmd[9]) begin
        wr_addr <= ADDR_SIZE'(cmd[7:0]);
        wa_set <= 1'b1;
      end
      if (cfg && cmd[9]) begin
        rd_addr <= ADDR_SIZE'(cmd[7:0]);
        ra_set <= 1'b1;
      end
      bus.ram_en <= spi_go || host_go;
      bus.host_gnt <= host_go;
      if (spi_go || host_go) begin
        bus.ram_we <= spi_go ? !cmd[9] : bus.host_we;
        bus.ram_addr <= spi_go ? (cmd[9] ? rd_addr : wr_addr) : bus.host_addr;
        bus.ram_wdata <= spi_go ? cmd[7:0] : bus.host_wdata;
        win_spi <= spi_go;
        is_rd <= spi_go ? cmd[9] : !bus.host_we;
      end
      if (spi_go && AUTO_INC && cmd[9]) rd_addr <= rd_addr + 1'b1;
      if (spi_go && AUTO_INC && !cmd[9]) wr_addr <= wr_addr + 1'b1;
      if (state == ACC) last_spi <= win_spi;
      bus.tx_valid <= state == RDCAP && win_spi;
      bus.host_rvalid <= state == RDCAP && !win_spi;
      if (state == RDCAP && win_spi) bus.tx_data <= bus.ram_rdata;
      if (state == RDCAP && !win_spi) bus.host_rdata <= bus.ram_rdata;
    end
  end
endmodule
